// File: rtl/armleocpu_clint_timebase.sv
// rtl/armleocpu_clint_timebase.sv - RISC-V CLINT (msip, mtimecmp, mtime) behind an AXI4-Lite slave
// Define CLINT_RTC_TICK_EN to clock mtime from the external rtc_tick instead of the prescaler.
module armleocpu_clint_timebase #(
  parameter int HART_COUNT       = 8,
  parameter int HART_COUNT_WIDTH = 3,
  parameter int TIMEBASE_DIV     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           AXI_AWADDR,
  input  logic                  AXI_AWVALID,
  output logic                  AXI_AWREADY,
  input  logic [31:0]           AXI_WDATA,
  input  logic [3:0]            AXI_WSTRB,
  input  logic                  AXI_WVALID,
  output logic                  AXI_WREADY,
  output logic [1:0]            AXI_BRESP,
  output logic                  AXI_BVALID,
  input  logic                  AXI_BREADY,
  input  logic [31:0]           AXI_ARADDR,
  input  logic                  AXI_ARVALID,
  output logic                  AXI_ARREADY,
  output logic [31:0]           AXI_RDATA,
  output logic [1:0]            AXI_RRESP,
  output logic                  AXI_RVALID,
  input  logic                  AXI_RREADY,
`ifdef CLINT_RTC_TICK_EN
  input  logic                  rtc_tick,
`endif
  output logic [HART_COUNT-1:0] hart_swi,
  output logic [HART_COUNT-1:0] hart_timeri
);

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_CMP, SEL_MTIME} sel_e;
  typedef struct packed {
    sel_e                        sel;
    logic                        hi;
    logic [HART_COUNT_WIDTH-1:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] addr);
    dec_t d;
    d.sel = SEL_NONE;
    d.hi  = addr[2];
    d.idx = '0;
    if (addr[31:16] == 16'h0 && addr[1:0] == 2'b00) begin
      if (addr[15:14] == 2'b00) begin
        if ({20'h0, addr[13:2]} < HART_COUNT) begin
          d.sel = SEL_MSIP;
          d.idx = addr[2 +: HART_COUNT_WIDTH];
        end
      end else if (addr[15:14] == 2'b01) begin
        if ({21'h0, addr[13:3]} < HART_COUNT) begin
          d.sel = SEL_CMP;
          d.idx = addr[3 +: HART_COUNT_WIDTH];
        end
      end else if (addr[15:3] == 13'h17FF) begin
        d.sel = SEL_MTIME;
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] wstrb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  state_e                state_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [HART_COUNT-1:0] msip_q;
  logic [HART_COUNT-1:0] timeri_q;
  logic [63:0]           mtimecmp_q [HART_COUNT];
  logic [63:0]           mtime_q, mtime_d;
  logic                  tick;
  dec_t                  wdec, rdec;
  logic                  wr_fire, rd_fire;

  assign wdec    = decode(AXI_AWADDR);
  assign rdec    = decode(AXI_ARADDR);
  // Write wins when both channels are pending in IDLE.
  assign wr_fire = (state_q == IDLE) && AXI_AWVALID && AXI_WVALID;
  assign rd_fire = (state_q == IDLE) && !wr_fire && AXI_ARVALID;

  assign AXI_AWREADY = wr_fire;
  assign AXI_WREADY  = wr_fire;
  assign AXI_ARREADY = rd_fire;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RRESP   = rresp_q;
  assign AXI_RDATA   = rdata_q;
  assign hart_swi    = msip_q;
  assign hart_timeri = timeri_q;

`ifdef CLINT_RTC_TICK_EN
  logic [2:0] rtc_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rtc_sync_q <= '0;
    else        rtc_sync_q <= {rtc_sync_q[1:0], rtc_tick};
  end

  assign tick = rtc_sync_q[1] & ~rtc_sync_q[2];
`else
  logic [15:0] presc_q;

  assign tick = (presc_q == 16'(TIMEBASE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= tick ? 16'd0 : presc_q + 16'd1;
  end
`endif

  // A software write replaces the increment; unwritten bytes keep the current value.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr_fire && wdec.sel == SEL_MTIME) begin
      mtime_d = mtime_q;
      if (wdec.hi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], AXI_WDATA, AXI_WSTRB);
      else         mtime_d[31:0]  = merge_bytes(mtime_q[31:0], AXI_WDATA, AXI_WSTRB);
    end
  end

  always_comb begin
    rdata_d = 32'h0;
    rresp_d = 2'b00;
    case (rdec.sel)
      SEL_MSIP:  rdata_d = {31'h0, msip_q[rdec.idx]};
      SEL_CMP:   rdata_d = rdec.hi ? mtimecmp_q[rdec.idx][63:32] : mtimecmp_q[rdec.idx][31:0];
      SEL_MTIME: rdata_d = rdec.hi ? mtime_q[63:32] : mtime_q[31:0];
      default:   rresp_d = 2'b10;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msip_q   <= '0;
      timeri_q <= '0;
      mtime_q  <= '0;
      for (int h = 0; h < HART_COUNT; h++) mtimecmp_q[h] <= '1;
    end else begin
      mtime_q <= mtime_d;
      for (int h = 0; h < HART_COUNT; h++) timeri_q[h] <= (mtime_q >= mtimecmp_q[h]);
      if (wr_fire && wdec.sel == SEL_MSIP && AXI_WSTRB[0]) msip_q[wdec.idx] <= AXI_WDATA[0];
      if (wr_fire && wdec.sel == SEL_CMP) begin
        if (wdec.hi)
          mtimecmp_q[wdec.idx][63:32] <= merge_bytes(mtimecmp_q[wdec.idx][63:32], AXI_WDATA, AXI_WSTRB);
        else
          mtimecmp_q[wdec.idx][31:0]  <= merge_bytes(mtimecmp_q[wdec.idx][31:0], AXI_WDATA, AXI_WSTRB);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_fire) begin
            state_q  <= WRESP;
            bvalid_q <= 1'b1;
            bresp_q  <= (wdec.sel == SEL_NONE) ? 2'b10 : 2'b00;
          end else if (rd_fire) begin
            state_q  <= RRESP;
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
          end
        end
        WRESP: begin
          if (AXI_BREADY) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        RRESP: begin
          if (AXI_RREADY) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_clint_timebase.sv
// tb/tb_armleocpu_clint_timebase.sv - randomized bench for armleocpu_clint_timebase against an arithmetic model
module tb_armleocpu_clint_timebase;
  localparam int HC  = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic          AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
  logic          AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
  logic [3:0]    AXI_WSTRB;
  logic [1:0]    AXI_BRESP, AXI_RRESP;
  logic [HC-1:0] hart_swi, hart_timeri;

  always #5 clk = ~clk;

  armleocpu_clint_timebase #(.HART_COUNT(HC), .HART_COUNT_WIDTH(3), .TIMEBASE_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .hart_swi(hart_swi), .hart_timeri(hart_timeri)
  );

  int total = 0;
  int bad   = 0;

  // Clock edges seen since reset was released; after n edges the prescaler has ticked n/DIV times.
  int unsigned edges = 0;
  always @(posedge clk) edges <= rst_n ? edges + 1 : 0;

  longint unsigned anc_val;
  int unsigned     anc_edge;
  longint unsigned m_cmp [HC];
  logic [HC-1:0]   m_msip;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    anc_val  = 0;
    anc_edge = 0;
    m_msip   = '0;
    for (int h = 0; h < HC; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  function automatic longint unsigned exp_mtime(input int unsigned n);
    return anc_val + 64'(n / DIV) - 64'(anc_edge / DIV);
  endfunction

  // 0 error, 1 msip, 2 mtimecmp, 3 mtime
  function automatic int decode_m(input logic [31:0] a, output int h, output bit hi);
    h  = 0;
    hi = a[2];
    if (a % 4 != 0 || a >= 32'h10000) return 0;
    if (a < 32'h4000) begin
      h = a / 4;
      return (h < HC) ? 1 : 0;
    end
    if (a < 32'h8000) begin
      h = (a - 32'h4000) / 8;
      return (h < HC) ? 2 : 0;
    end
    if (a == 32'hBFF8 || a == 32'hBFFC) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s, input int unsigned w);
    int h;
    bit hi;
    longint unsigned v;
    case (decode_m(a, h, hi))
      1: begin
        if (s[0]) m_msip[h] = d[0];
        return 2'b00;
      end
      2: begin
        v = m_cmp[h];
        if (hi) v[63:32] = mrg(v[63:32], d, s); else v[31:0] = mrg(v[31:0], d, s);
        m_cmp[h] = v;
        return 2'b00;
      end
      3: begin
        v = exp_mtime(w - 1);
        if (hi) v[63:32] = mrg(v[63:32], d, s); else v[31:0] = mrg(v[31:0], d, s);
        anc_val  = v;
        anc_edge = w;
        return 2'b00;
      end
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_read(input logic [31:0] a, input int unsigned n,
                            output logic [31:0] d, output logic [1:0] resp);
    int h;
    bit hi;
    longint unsigned v;
    d    = 32'h0;
    resp = 2'b00;
    case (decode_m(a, h, hi))
      1: d = {31'h0, m_msip[h]};
      2: begin v = m_cmp[h]; d = hi ? v[63:32] : v[31:0]; end
      3: begin v = exp_mtime(n); d = hi ? v[63:32] : v[31:0]; end
      default: resp = 2'b10;
    endcase
  endtask

  task automatic check_irq();
    logic [HC-1:0] et;
    longint unsigned mt;
    @(negedge clk);
    mt = exp_mtime(edges - 1);
    for (int h = 0; h < HC; h++) et[h] = (mt >= m_cmp[h]);
    chk("hart_swi", 64'(hart_swi), 64'(m_msip));
    chk("hart_timeri", 64'(hart_timeri), 64'(et));
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdelay);
    bit ok;
    logic [1:0] eb;
    @(negedge clk);
    AXI_AWADDR  = a;
    AXI_WDATA   = d;
    AXI_WSTRB   = s;
    AXI_AWVALID = 1'b1;
    for (int i = 0; i < lead; i++) begin
      #1;
      chk("aw_alone_ready", 64'({AXI_AWREADY, AXI_WREADY}), 64'(0));
      @(negedge clk);
    end
    AXI_WVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (AXI_AWREADY && AXI_WREADY) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("aw_w_timeout", 64'(0), 64'(1));
      AXI_AWVALID = 1'b0;
      AXI_WVALID  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    eb = model_write(a, d, s, edges);
    for (int i = 0; i <= bdelay; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 64'(AXI_BVALID), 64'(1));
      chk("bresp", 64'(AXI_BRESP), 64'(eb));
    end
    AXI_BREADY = 1'b1;
    @(posedge clk);
    #1;
    AXI_BREADY = 1'b0;
    chk("bvalid_clear", 64'(AXI_BVALID), 64'(0));
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay);
    bit ok;
    logic [31:0] ed;
    logic [1:0] er;
    @(negedge clk);
    AXI_ARADDR  = a;
    AXI_ARVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (AXI_ARREADY) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("ar_timeout", 64'(0), 64'(1));
      AXI_ARVALID = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    AXI_ARVALID = 1'b0;
    model_read(a, edges - 1, ed, er);
    for (int i = 0; i <= rdelay; i++) begin
      @(negedge clk);
      chk("rvalid_hold", 64'(AXI_RVALID), 64'(1));
      chk("rdata", 64'(AXI_RDATA), 64'(ed));
      chk("rresp", 64'(AXI_RRESP), 64'(er));
    end
    AXI_RREADY = 1'b1;
    @(posedge clk);
    #1;
    AXI_RREADY = 1'b0;
    chk("rvalid_clear", 64'(AXI_RVALID), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    rst_n       = 1'b0;
    AXI_AWADDR  = '0; AXI_AWVALID = 1'b0; AXI_WDATA  = '0; AXI_WSTRB  = '0; AXI_WVALID = 1'b0;
    AXI_BREADY  = 1'b0; AXI_ARADDR = '0; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_bvalid", 64'(AXI_BVALID), 64'(0));
    chk("rst_rvalid", 64'(AXI_RVALID), 64'(0));
    chk("rst_rdata", 64'(AXI_RDATA), 64'(0));
    chk("rst_resp", 64'({AXI_BRESP, AXI_RRESP}), 64'(0));
    chk("rst_ready", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'(0));
    chk("rst_irq", 64'({hart_swi, hart_timeri}), 64'(0));
    rst_n = 1'b1;

    axi_read(32'h4000, 0);
    axi_read(32'h4004, 1);
    axi_read(32'hBFF8, 0);
    repeat (6) @(negedge clk);
    axi_read(32'hBFF8, 0);

    axi_write(32'h0008, 32'h1, 4'h1, 0, 0);
    check_irq();
    axi_write(32'h0008, 32'h0, 4'h0, 0, 0);
    check_irq();

    axi_write(32'hBFF8, 32'h0, 4'hF, 0, 0);
    axi_write(32'hBFFC, 32'h0, 4'hF, 0, 0);
    axi_write(32'h400C, 32'h0, 4'hF, 0, 0);
    axi_write(32'h4008, 32'h10, 4'hF, 0, 0);
    repeat (80) check_irq();
    axi_write(32'h400C, 32'h1, 4'hF, 0, 1);
    check_irq();

    axi_write(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(32'hBFFC, 32'h0, 4'hF, 0, 0);
    repeat (5) @(negedge clk);
    axi_read(32'hBFFC, 0);
    axi_read(32'hBFF8, 0);
    axi_write(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    repeat (5) @(negedge clk);
    axi_read(32'hBFFC, 0);
    axi_read(32'hBFF8, 0);

    // Land the handshake exactly on a prescaler tick edge.
    do @(negedge clk); while (edges % DIV != DIV - 2);
    axi_write(32'hBFF8, 32'h100, 4'hF, 0, 0);
    axi_read(32'hBFF8, 0);

    axi_read(32'h4000 + 8 * HC, 0);
    axi_read(32'h0002, 0);
    axi_write(32'h8000, 32'h1, 4'hF, 0, 0);
    check_irq();
    axi_write(32'h4000, 32'h20, 4'h3, 5, 3);
    axi_read(32'h4000, 2);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'(4 * $urandom_range(0, HC + 1));
        1, 2:    a = 32'h4000 + 32'(8 * $urandom_range(0, HC + 1)) + 32'(4 * $urandom_range(0, 1));
        3:       a = 32'hBFF8 + 32'(4 * $urandom_range(0, 1));
        4:       a = 32'h4000 + 32'($urandom_range(1, 3));
        default: a = ($urandom_range(0, 1) != 0) ? 32'h8000 : 32'h0001_0000;
      endcase
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 96));
      if ($urandom_range(0, 1) != 0)
        axi_write(a, d, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        axi_read(a, int'($urandom_range(0, 2)));
      check_irq();
    end

    @(negedge clk);
    AXI_ARADDR  = 32'hBFF8;
    AXI_ARVALID = 1'b1;
    @(posedge clk);
    #1;
    AXI_ARVALID = 1'b0;
    chk("pre_abort_rvalid", 64'(AXI_RVALID), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rvalid", 64'(AXI_RVALID), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_irq();
    axi_read(32'h4004, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
